cpu_sequencer: RTL and testbench

CPU_SEQUENCER -- requirements
Module: cpu_sequencer

---
 rtl/cpu_pkg.sv | 40 ++++
 rtl/cpu_sequencer_depthcounter.sv | 48 ++++
 rtl/cpu_sequencer.sv | 238 +++++++++++++++++++++++
 tb/tb_cpu_sequencer.sv | 363 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// ---------------------------------------------------------------------------
// cpu_pkg
// Shared definitions for the CPU sequencer: FSM state encoding, instruction
// class codes, stack sub-op codes and stack-pointer control encodings.
// No ports; imported by cpu_sequencer and depthcounter.
// ---------------------------------------------------------------------------
package cpu_pkg;

    // Sequencer states
    typedef enum logic [2:0] {
        ST_FETCH = 3'd0,
        ST_EXEC  = 3'd1,
        ST_WB    = 3'd2,
        ST_HALT  = 3'd3,
        ST_FAULT = 3'd4
    } state_e;

    // Instruction class, IR[0:1]
    localparam logic [1:0] CLS_LIT = 2'b00;
    localparam logic [1:0] CLS_ALU = 2'b01;
    localparam logic [1:0] CLS_JMP = 2'b10;
    localparam logic [1:0] CLS_STK = 2'b11;

    // Stack sub-op, IR[2:4]
    localparam logic [2:0] STK_POP   = 3'b000;
    localparam logic [2:0] STK_DROP  = 3'b001;
    localparam logic [2:0] STK_PUSHR = 3'b010;
    localparam logic [2:0] STK_HALT  = 3'b011;

    // Stack pointer control {select, inc, dec}
    localparam logic [2:0] SP_NONE = 3'b000;
    localparam logic [2:0] SP_INC  = 3'b010;
    localparam logic [2:0] SP_DEC  = 3'b001;

    // True when a stack sub-op moves the stack pointer downwards
    function automatic logic isStackPop(input logic [2:0] stkOp);
        return (stkOp == STK_POP) || (stkOp == STK_DROP);
    endfunction

endpackage

// File: rtl/cpu_sequencer_depthcounter.sv
// ---------------------------------------------------------------------------
// depthcounter
// Tracks the memory stack occupancy and flags overflow/underflow.
// Ports:
//   i_clock, i_reset_n : clock, async active-low reset
//   i_push, i_pop      : requested stack movement this cycle (one-hot or none)
//   o_depth            : current occupancy
//   o_fault            : combinational; the requested movement is illegal.
//                        The counter holds its value when this is set.
// ---------------------------------------------------------------------------
module depthcounter #(
    parameter int  STACK_DEPTH = 16,
    localparam int DW          = $clog2(STACK_DEPTH + 1)
) (
    input  logic          i_clock,
    input  logic          i_reset_n,
    input  logic          i_push,
    input  logic          i_pop,
    output logic [DW-1:0] o_depth,
    output logic          o_fault
);

    localparam logic [DW-1:0] DEPTH_FULL = DW'(STACK_DEPTH);
    localparam logic [DW-1:0] DEPTH_ZERO = DW'(0);
    localparam logic [DW-1:0] DEPTH_ONE  = DW'(1);

    logic [DW-1:0] depth_r;

    assign o_fault = (i_push && (depth_r == DEPTH_FULL)) ||
                     (i_pop  && (depth_r == DEPTH_ZERO));
    assign o_depth = depth_r;

    // Occupancy register: moves only on a legal push or pop
    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            depth_r <= DEPTH_ZERO;
        end else if (o_fault) begin
            depth_r <= depth_r;
        end else if (i_push) begin
            depth_r <= depth_r + DEPTH_ONE;
        end else if (i_pop) begin
            depth_r <= depth_r - DEPTH_ONE;
        end else begin
            depth_r <= depth_r;
        end
    end

endmodule

// File: rtl/cpu_sequencer.sv
// ---------------------------------------------------------------------------
// cpu_sequencer
// Fetch/execute/writeback control sequencer for an 18-bit stack CPU.
// Ports:
//   i_clock, i_reset_n : clock, async active-low reset
//   i_run              : fetch enable, only sampled in FETCH
//   i_instruction      : program ROM word, bits [0:17]
//   i_cond             : jump-assist condition, selects IP source on JMP
//   o_* strobes        : datapath controls, combinational from state/IR/depth
//   o_halted, o_fault  : sticky status (until reset)
//   o_depth            : current stack occupancy
// ---------------------------------------------------------------------------
module cpu_sequencer #(
    parameter int STACK_DEPTH = 16
) (
    input  logic                             i_clock,
    input  logic                             i_reset_n,
    input  logic                             i_run,
    input  logic [0:17]                      i_instruction,
    input  logic                             i_cond,
    output logic                             o_ipWrite,
    output logic                             o_ipSel,
    output logic                             o_RWCtrl,
    output logic                             o_RSCtrl,
    output logic                             o_TWCtrl,
    output logic                             o_TIn,
    output logic                             o_stkAddrSel,
    output logic                             o_stkWCtrl,
    output logic                             o_stkSCtrl,
    output logic                             o_carryWCtrl,
    output logic                             o_instrTypeCtrl,
    output logic [4:0]                       o_instrOP,
    output logic [2:0]                       o_spCtrl,
    output logic [1:0]                       o_jSelCtrl,
    output logic [5:0]                       o_jCtrl,
    output logic                             o_halted,
    output logic                             o_fault,
    output logic [$clog2(STACK_DEPTH+1)-1:0] o_depth
);

    import cpu_pkg::*;

    state_e      state_r;
    state_e      nextState_s;
    logic [0:17] ir_r;
    logic [1:0]  irClass_s;
    logic [2:0]  stkOp_s;
    logic        pushReq_s;
    logic        popReq_s;
    logic        stackFault_s;
    logic        unusedIrBits_s;

    assign irClass_s = ir_r[0:1];
    assign stkOp_s   = ir_r[2:4];
    // Literal payload bits travel on the datapath, not through the sequencer
    assign unusedIrBits_s = ^ir_r[10:17];

    // State and instruction register; IR only loads on an accepted fetch
    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_r <= ST_FETCH;
            ir_r    <= 18'd0;
        end else begin
            state_r <= nextState_s;
            if ((state_r == ST_FETCH) && i_run) begin
                ir_r <= i_instruction;
            end else begin
                ir_r <= ir_r;
            end
        end
    end

    // Stack movement requests, kept apart from the strobe decode so the
    // fault flag coming back from the counter forms no combinational loop
    always_comb begin
        pushReq_s = 1'b0;
        popReq_s  = 1'b0;
        case (state_r)
            ST_EXEC: begin
                if (irClass_s == CLS_STK) begin
                    pushReq_s = (stkOp_s == STK_PUSHR);
                    popReq_s  = isStackPop(stkOp_s);
                end else begin
                    pushReq_s = 1'b0;
                    popReq_s  = 1'b0;
                end
            end
            ST_WB: begin
                // WB is only reached by an ALU op that pushes R
                pushReq_s = 1'b1;
            end
            default: begin
                pushReq_s = 1'b0;
                popReq_s  = 1'b0;
            end
        endcase
    end

    depthcounter #(
        .STACK_DEPTH (STACK_DEPTH)
    ) uDepthCounter (
        .i_clock   (i_clock),
        .i_reset_n (i_reset_n),
        .i_push    (pushReq_s),
        .i_pop     (popReq_s),
        .o_depth   (o_depth),
        .o_fault   (stackFault_s)
    );

    // Next-state and strobe decode; a stack fault suppresses every strobe
    always_comb begin
        nextState_s     = state_r;
        o_ipWrite       = 1'b0;
        o_ipSel         = 1'b0;
        o_RWCtrl        = 1'b0;
        o_RSCtrl        = 1'b0;
        o_TWCtrl        = 1'b0;
        o_TIn           = 1'b0;
        o_stkAddrSel    = 1'b0;
        o_stkWCtrl      = 1'b0;
        o_stkSCtrl      = 1'b0;
        o_carryWCtrl    = 1'b0;
        o_instrTypeCtrl = 1'b0;
        o_instrOP       = 5'd0;
        o_spCtrl        = SP_NONE;
        o_jSelCtrl      = 2'd0;
        o_jCtrl         = 6'd0;
        o_halted        = 1'b0;
        o_fault         = 1'b0;

        case (state_r)
            ST_FETCH: begin
                if (i_run) begin
                    nextState_s = ST_EXEC;
                end else begin
                    nextState_s = ST_FETCH;
                end
            end

            ST_EXEC: begin
                case (irClass_s)
                    CLS_LIT: begin
                        o_TIn       = 1'b0;
                        o_TWCtrl    = 1'b1;
                        o_ipWrite   = 1'b1;
                        o_ipSel     = 1'b0;
                        nextState_s = ST_FETCH;
                    end
                    CLS_ALU: begin
                        o_instrTypeCtrl = 1'b0;
                        o_instrOP       = ir_r[2:6];
                        o_RWCtrl        = 1'b1;
                        o_carryWCtrl    = ir_r[7];
                        if (ir_r[8]) begin
                            nextState_s = ST_WB;
                        end else begin
                            o_ipWrite   = 1'b1;
                            nextState_s = ST_FETCH;
                        end
                    end
                    CLS_JMP: begin
                        // Taken jump (i_cond=1) loads IP from T
                        o_jCtrl     = ir_r[2:7];
                        o_jSelCtrl  = ir_r[8:9];
                        o_ipSel     = i_cond;
                        o_ipWrite   = 1'b1;
                        nextState_s = ST_FETCH;
                    end
                    CLS_STK: begin
                        if (stackFault_s) begin
                            nextState_s = ST_FAULT;
                        end else begin
                            case (stkOp_s)
                                STK_POP: begin
                                    o_stkSCtrl  = 1'b1;
                                    o_TIn       = 1'b1;
                                    o_TWCtrl    = 1'b1;
                                    o_spCtrl    = SP_DEC;
                                    o_ipWrite   = 1'b1;
                                    nextState_s = ST_FETCH;
                                end
                                STK_DROP: begin
                                    o_spCtrl    = SP_DEC;
                                    o_ipWrite   = 1'b1;
                                    nextState_s = ST_FETCH;
                                end
                                STK_PUSHR: begin
                                    o_RSCtrl    = 1'b1;
                                    o_stkWCtrl  = 1'b1;
                                    o_spCtrl    = SP_INC;
                                    o_ipWrite   = 1'b1;
                                    nextState_s = ST_FETCH;
                                end
                                STK_HALT: begin
                                    nextState_s = ST_HALT;
                                end
                                default: begin
                                    o_ipWrite   = 1'b1;
                                    nextState_s = ST_FETCH;
                                end
                            endcase
                        end
                    end
                    default: begin
                        nextState_s = ST_FETCH;
                    end
                endcase
            end

            ST_WB: begin
                if (stackFault_s) begin
                    nextState_s = ST_FAULT;
                end else begin
                    o_RSCtrl    = 1'b1;
                    o_stkWCtrl  = 1'b1;
                    o_spCtrl    = SP_INC;
                    o_ipWrite   = 1'b1;
                    nextState_s = ST_FETCH;
                end
            end

            ST_HALT: begin
                o_halted    = 1'b1;
                nextState_s = ST_HALT;
            end

            ST_FAULT: begin
                o_fault     = 1'b1;
                nextState_s = ST_FAULT;
            end

            default: begin
                nextState_s = ST_FETCH;
            end
        endcase
    end

endmodule

// File: tb/tb_cpu_sequencer.sv
// ---------------------------------------------------------------------------
// tb_cpu_sequencer
// Scoreboard bench: the driver expands each fetched instruction into the
// list of cycle-by-cycle outputs it should produce and queues them; a
// negedge monitor pops one expected output per driven cycle and compares.
// ---------------------------------------------------------------------------
module tb_cpu_sequencer;

    localparam int DEPTH = 16;

    typedef struct packed {
        logic       ipWrite;
        logic       ipSel;
        logic       RWCtrl;
        logic       RSCtrl;
        logic       TWCtrl;
        logic       TIn;
        logic       stkAddrSel;
        logic       stkWCtrl;
        logic       stkSCtrl;
        logic       carryWCtrl;
        logic       instrTypeCtrl;
        logic [4:0] instrOP;
        logic [2:0] spCtrl;
        logic [1:0] jSelCtrl;
        logic [5:0] jCtrl;
        logic       halted;
        logic       fault;
        logic [4:0] depth;
    } outv_t;

    typedef struct {
        outv_t v;
        string tag;
    } exp_t;

    typedef struct {
        outv_t v;
        logic  cond;
    } pend_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        run;
    logic [0:17] instr;
    logic        cond;

    logic        ipWrite, ipSel, RWCtrl, RSCtrl, TWCtrl, TIn, stkAddrSel;
    logic        stkWCtrl, stkSCtrl, carryWCtrl, instrTypeCtrl, halted, fault;
    logic [4:0]  instrOP;
    logic [2:0]  spCtrl;
    logic [1:0]  jSelCtrl;
    logic [5:0]  jCtrl;
    logic [4:0]  depth;
    outv_t       obs;

    exp_t  sbq[$];
    pend_t pend[$];
    int    mDepth = 0;
    int    mMode  = 0;   // 0 running, 1 halted, 2 faulted
    int    vectors = 0;
    int    errors  = 0;

    localparam logic [0:17] I_LIT   = {2'b00, 16'h1234};
    localparam logic [0:17] I_ALUP  = {2'b01, 5'b01001, 1'b1, 1'b1, 9'd0};
    localparam logic [0:17] I_JMP   = {2'b10, 6'b101101, 2'b10, 8'd0};
    localparam logic [0:17] I_PUSHR = {2'b11, 3'b010, 13'd0};
    localparam logic [0:17] I_POP   = {2'b11, 3'b000, 13'd0};
    localparam logic [0:17] I_HALT  = {2'b11, 3'b011, 13'd0};

    always #5 clk = ~clk;

    cpu_sequencer #(.STACK_DEPTH(DEPTH)) dut (
        .i_clock         (clk),
        .i_reset_n       (rst_n),
        .i_run           (run),
        .i_instruction   (instr),
        .i_cond          (cond),
        .o_ipWrite       (ipWrite),
        .o_ipSel         (ipSel),
        .o_RWCtrl        (RWCtrl),
        .o_RSCtrl        (RSCtrl),
        .o_TWCtrl        (TWCtrl),
        .o_TIn           (TIn),
        .o_stkAddrSel    (stkAddrSel),
        .o_stkWCtrl      (stkWCtrl),
        .o_stkSCtrl      (stkSCtrl),
        .o_carryWCtrl    (carryWCtrl),
        .o_instrTypeCtrl (instrTypeCtrl),
        .o_instrOP       (instrOP),
        .o_spCtrl        (spCtrl),
        .o_jSelCtrl      (jSelCtrl),
        .o_jCtrl         (jCtrl),
        .o_halted        (halted),
        .o_fault         (fault),
        .o_depth         (depth)
    );

    assign obs = {ipWrite, ipSel, RWCtrl, RSCtrl, TWCtrl, TIn, stkAddrSel,
                  stkWCtrl, stkSCtrl, carryWCtrl, instrTypeCtrl, instrOP,
                  spCtrl, jSelCtrl, jCtrl, halted, fault, depth};

    task automatic check(input string tag, input outv_t act, input outv_t exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    // Monitor: one expected output per driven cycle, compared mid-cycle
    always @(negedge clk) begin
        if (sbq.size() > 0) begin
            exp_t x;
            x = sbq.pop_front();
            check(x.tag, obs, x.v);
        end
    end

    function automatic void queueCycle(input outv_t e, input logic c);
        pend_t p;
        p.v    = e;
        p.cond = c;
        pend.push_back(p);
    endfunction

    // Reference: turn one instruction into its execution cycles
    function automatic void expand(input logic [0:17] ins, input logic c);
        int         d;
        outv_t      e;
        logic [2:0] sub;
        d   = mDepth;
        sub = ins[2:4];
        e   = '0;
        e.depth = 5'(d);
        case (ins[0:1])
            2'b00: begin
                e.TWCtrl  = 1'b1;
                e.ipWrite = 1'b1;
                queueCycle(e, c);
            end
            2'b01: begin
                e.instrOP    = ins[2:6];
                e.RWCtrl     = 1'b1;
                e.carryWCtrl = ins[7];
                e.ipWrite    = ~ins[8];
                queueCycle(e, c);
                if (ins[8]) begin
                    e = '0;
                    e.depth = 5'(d);
                    if (d == DEPTH) begin
                        queueCycle(e, c);
                        mMode = 2;
                    end else begin
                        e.RSCtrl   = 1'b1;
                        e.stkWCtrl = 1'b1;
                        e.spCtrl   = 3'b010;
                        e.ipWrite  = 1'b1;
                        queueCycle(e, c);
                        d = d + 1;
                    end
                end
            end
            2'b10: begin
                e.jCtrl    = ins[2:7];
                e.jSelCtrl = ins[8:9];
                e.ipSel    = c;
                e.ipWrite  = 1'b1;
                queueCycle(e, c);
            end
            default: begin
                if (sub == 3'd3) begin
                    queueCycle(e, c);
                    mMode = 1;
                end else if ((sub <= 3'd1 && d == 0) || (sub == 3'd2 && d == DEPTH)) begin
                    queueCycle(e, c);
                    mMode = 2;
                end else begin
                    e.ipWrite = 1'b1;
                    if (sub == 3'd0) begin
                        e.stkSCtrl = 1'b1;
                        e.TIn      = 1'b1;
                        e.TWCtrl   = 1'b1;
                    end
                    if (sub <= 3'd1) begin
                        e.spCtrl = 3'b001;
                        d = d - 1;
                    end
                    if (sub == 3'd2) begin
                        e.RSCtrl   = 1'b1;
                        e.stkWCtrl = 1'b1;
                        e.spCtrl   = 3'b010;
                        d = d + 1;
                    end
                    queueCycle(e, c);
                end
            end
        endcase
        mDepth = d;
    endfunction

    // Drive one cycle and queue what the DUT should show during it
    task automatic step(input logic r, input logic [0:17] ins, input logic c);
        exp_t  x;
        pend_t p;
        @(posedge clk);
        #1;
        x.v = '0;
        if (pend.size() > 0) begin
            p     = pend.pop_front();
            x.v   = p.v;
            x.tag = "exec";
            run   = 1'($urandom);        // must be ignored mid-instruction
            instr = 18'($urandom);
            cond  = p.cond;
        end else begin
            run   = r;
            instr = ins;
            cond  = 1'($urandom);
            x.v.depth = 5'(mDepth);
            if (mMode == 1) begin
                x.v.halted = 1'b1;
                x.tag = "halted";
            end else if (mMode == 2) begin
                x.v.fault = 1'b1;
                x.tag = "fault";
            end else begin
                x.tag = "fetch";
                if (r) expand(ins, c);
            end
        end
        sbq.push_back(x);
    endtask

    task automatic issue(input logic [0:17] ins, input logic c);
        step(1'b1, ins, c);
        while (pend.size() > 0) step(1'b0, 18'd0, 1'b0);
    endtask

    task automatic doReset();
        outv_t z;
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        run   = 1'b0;
        pend.delete();
        mMode  = 0;
        mDepth = 0;
        #2;
        z = '0;
        check("reset_outputs", obs, z);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    function automatic logic [0:17] randSafe();
        logic [0:17] r;
        logic [2:0]  sub;
        r   = 18'($urandom);
        sub = r[2:4];
        if (r[0:1] == 2'b11) begin
            if (sub == 3'd3) sub = 3'd7;
            if (sub <= 3'd1 && mDepth == 0) sub = 3'd2;
            if (sub == 3'd2 && mDepth == DEPTH) sub = 3'd0;
            r[2:4] = sub;
        end
        if (r[0:1] == 2'b01 && mDepth == DEPTH) r[8] = 1'b0;
        return r;
    endfunction

    // Reset asserted while the ALU writeback is on the bus
    task automatic resetInWb();
        pend_t p;
        outv_t z;
        step(1'b1, I_ALUP, 1'b0);
        step(1'b0, 18'd0, 1'b0);
        @(posedge clk);
        #1;
        p = pend.pop_front();
        check("wb_before_reset", obs, p.v);
        rst_n = 1'b0;
        run   = 1'b0;
        #1;
        z = '0;
        check("wb_reset_strobes", obs, z);
        pend.delete();
        mMode  = 0;
        mDepth = 0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        outv_t z;
        rst_n = 1'b0;
        run   = 1'b0;
        instr = 18'd0;
        cond  = 1'b0;
        #12;
        z = '0;
        check("power_on_reset", obs, z);
        @(negedge clk);
        rst_n = 1'b1;

        // run gating: random words offered while i_run is low
        for (int i = 0; i < 10; i++) step(1'b0, 18'($urandom), 1'b0);

        issue(I_LIT, 1'b0);
        issue(I_ALUP, 1'b0);
        issue(I_JMP, 1'b1);
        issue(I_JMP, 1'b0);
        step(1'b0, 18'd0, 1'b0);

        // randomized mix, steered away from faults and halt
        for (int i = 0; i < 250; i++) begin
            if ($urandom_range(0, 3) == 0) step(1'b0, 18'($urandom), 1'b0);
            issue(randSafe(), 1'($urandom));
        end

        // overflow: fill the stack, then one push too many
        doReset();
        for (int i = 0; i < DEPTH; i++) issue(I_PUSHR, 1'b0);
        step(1'b0, 18'd0, 1'b0);
        issue(I_PUSHR, 1'b0);
        for (int i = 0; i < 4; i++) step(1'b1, I_LIT, 1'b0);

        // ALU writeback push at a full stack
        doReset();
        for (int i = 0; i < DEPTH; i++) issue(I_PUSHR, 1'b0);
        issue(I_ALUP, 1'b0);
        for (int i = 0; i < 3; i++) step(1'b1, I_POP, 1'b0);

        // underflow
        doReset();
        issue(I_POP, 1'b0);
        for (int i = 0; i < 3; i++) step(1'b1, I_PUSHR, 1'b0);

        // halt is sticky
        doReset();
        issue(I_PUSHR, 1'b0);
        issue(I_HALT, 1'b0);
        for (int i = 0; i < 5; i++) step(1'b1, I_LIT, 1'b0);

        // reset during writeback, then resume normally
        doReset();
        issue(I_PUSHR, 1'b0);
        resetInWb();
        step(1'b0, 18'd0, 1'b0);
        issue(I_LIT, 1'b0);
        step(1'b0, 18'd0, 1'b0);

        @(posedge clk);
        #1;
        vectors++;
        if (sbq.size() != 0) begin
            errors++;
            $display("FAIL sb_drain: %0d expected outputs never checked, required 0", sbq.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
